// File: rtl/inv_mod_761_if.sv
// inv_mod_761_if: operand/result handshake bundle for the mod-761 inverter.
//   in_valid/in_ready/in_a     : operand channel (master drives valid/data)
//   out_valid/out_ready/out_r  : result channel (slave drives valid/data)
//   out_zero                   : operand was congruent to 0 mod 761
//   out_err                    : self-check failure (only with INV761_SELFCHECK_EN)
interface inv_mod_761_if;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_a;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_r;
  logic       out_zero;
`ifdef INV761_SELFCHECK_EN
  logic       out_err;
`endif

  modport master (
    output in_valid, in_a, out_ready,
    input  in_ready, out_valid, out_r, out_zero
`ifdef INV761_SELFCHECK_EN
    , input out_err
`endif
  );

  modport slave (
    input  in_valid, in_a, out_ready,
    output in_ready, out_valid, out_r, out_zero
`ifdef INV761_SELFCHECK_EN
    , output out_err
`endif
  );
endinterface

// File: rtl/inv_mod_761.sv
// inv_mod_761: sequential inverse mod 761 as a^759 (Fermat), left-to-right
// square-and-multiply, one 20-bit Barrett reduction per cycle.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : inv_mod_761_if.slave (operand in, result out, out_zero[, out_err])
// Optional feature: define INV761_SELFCHECK_EN to add a CHK state that
// multiplies the result back by the operand and flags out_err if it is not 1.
//
// state | meaning
// IDLE  | waiting for operand, in_ready=1
// SQR   | acc = acc^2 mod 761
// MUL   | acc = acc*base mod 761
// CHK   | prod = acc*base mod 761 (self-check build only)
// DONE  | result presented, held until out_ready
module inv_mod_761 (
  input logic          clk,
  input logic          rst,
  inv_mod_761_if.slave bus
);
  localparam logic [9:0]  Q   = 10'd761;
  localparam logic [9:0]  EXP = 10'd759;
  localparam logic [30:0] MU  = 31'd1377;

`ifdef INV761_SELFCHECK_EN
  typedef enum logic [2:0] {IDLE, SQR, MUL, CHK, DONE} state_t;
  localparam state_t LAST_NEXT = CHK;
`else
  typedef enum logic [2:0] {IDLE, SQR, MUL, DONE} state_t;
  localparam state_t LAST_NEXT = DONE;
`endif

  // Barrett quotient underestimates by at most 2, so r < 3*761 fits 12 bits
  // and the true remainder survives truncation of the subtraction.
  function automatic logic [9:0] red(input logic [19:0] x);
    logic [10:0] t;
    logic [11:0] r;
    t = 11'(({11'd0, x} * MU) >> 20);
    r = 12'({1'b0, x} - ({10'd0, t} * 21'd761));
    if (r >= 12'd761) r = r - 12'd761;
    if (r >= 12'd761) r = r - 12'd761;
    return 10'(r);
  endfunction

  state_t     state_q, state_d;
  logic [9:0] acc_q, acc_d;
  logic [9:0] base_q, base_d;
  logic [3:0] idx_q, idx_d;
  logic       out_valid_q, out_valid_d;
  logic [9:0] out_r_q, out_r_d;
  logic       out_zero_q, out_zero_d;
`ifdef INV761_SELFCHECK_EN
  logic [9:0] prod_q, prod_d;
  logic       out_err_q, out_err_d;
`endif

  logic [9:0]  mul_b;
  logic [9:0]  red_r;

  // One shared multiplier: squares in SQR, multiplies by base otherwise.
  always_comb begin
    mul_b = (state_q == SQR) ? acc_q : base_q;
    red_r = red({10'd0, acc_q} * {10'd0, mul_b});
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    base_d      = base_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_r_d     = out_r_q;
    out_zero_d  = out_zero_q;
`ifdef INV761_SELFCHECK_EN
    prod_d      = prod_q;
    out_err_d   = out_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          base_d  = (bus.in_a >= Q) ? bus.in_a - Q : bus.in_a;
          acc_d   = 10'd1;
          idx_d   = 4'd9;
          state_d = SQR;
        end
      end
      SQR: begin
        acc_d = red_r;
        if (EXP[idx_q])         state_d = MUL;
        else if (idx_q == 4'd0) state_d = LAST_NEXT;
        else                    idx_d   = idx_q - 4'd1;
      end
      MUL: begin
        acc_d = red_r;
        if (idx_q == 4'd0) state_d = LAST_NEXT;
        else begin
          idx_d   = idx_q - 4'd1;
          state_d = SQR;
        end
      end
`ifdef INV761_SELFCHECK_EN
      CHK: begin
        prod_d  = red_r;
        state_d = DONE;
      end
`endif
      DONE: begin
        // First DONE cycle loads the result registers; later cycles wait.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_r_d     = acc_q;
          out_zero_d  = (base_q == 10'd0);
`ifdef INV761_SELFCHECK_EN
          out_err_d   = (base_q != 10'd0) && (prod_q != 10'd1);
`endif
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= 10'd1;
      base_q      <= 10'd0;
      idx_q       <= 4'd9;
      out_valid_q <= 1'b0;
      out_r_q     <= 10'd0;
      out_zero_q  <= 1'b0;
`ifdef INV761_SELFCHECK_EN
      prod_q      <= 10'd0;
      out_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      base_q      <= base_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_zero_q  <= out_zero_d;
`ifdef INV761_SELFCHECK_EN
      prod_q      <= prod_d;
      out_err_q   <= out_err_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_r     = out_r_q;
  assign bus.out_zero  = out_zero_q;
`ifdef INV761_SELFCHECK_EN
  assign bus.out_err   = out_err_q;
`endif
endmodule

// File: tb/tb_inv_mod_761.sv
module tb_inv_mod_761;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

`ifdef INV761_SELFCHECK_EN
  localparam int LAT = 20;
`else
  localparam int LAT = 19;
`endif

  inv_mod_761_if ifc ();

  inv_mod_761 dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Independent reference: search for r with r*a == 1 mod 761.
  function automatic int ref_inv(input int a);
    int am = a % 761;
    for (int r = 1; r < 761; r++)
      if ((r * am) % 761 == 1) return r;
    return 0;
  endfunction

  task automatic wait_valid(input string tag);
    int lat = 0;
    while (ifc.out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, LAT);
  endtask

  task automatic run_op(input string tag, input logic [9:0] a,
                        input logic [9:0] exp_r, input logic exp_zero);
    @(negedge clk);
    check({tag, "_in_ready"}, {31'd0, ifc.in_ready}, 1);
    ifc.in_valid = 1'b1;
    ifc.in_a     = a;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    wait_valid(tag);
    check({tag, "_out_r"}, {22'd0, ifc.out_r}, {22'd0, exp_r});
    check({tag, "_out_zero"}, {31'd0, ifc.out_zero}, {31'd0, exp_zero});
`ifdef INV761_SELFCHECK_EN
    check({tag, "_out_err"}, {31'd0, ifc.out_err}, 0);
`endif
    @(posedge clk); #1;
    check({tag, "_handoff_valid"}, {31'd0, ifc.out_valid}, 0);
    check({tag, "_handoff_ready"}, {31'd0, ifc.in_ready}, 1);
  endtask

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.in_a      = 10'd0;
    ifc.out_ready = 1'b1;
    #12;
    check("rst_in_ready",  {31'd0, ifc.in_ready}, 1);
    check("rst_out_valid", {31'd0, ifc.out_valid}, 0);
    check("rst_out_r",     {22'd0, ifc.out_r}, 0);
    check("rst_out_zero",  {31'd0, ifc.out_zero}, 0);
`ifdef INV761_SELFCHECK_EN
    check("rst_out_err",   {31'd0, ifc.out_err}, 0);
`endif
    @(negedge clk); rst = 1'b0;

    run_op("a1",   10'd1,   10'd1,   1'b0);
    run_op("a2",   10'd2,   10'd381, 1'b0);
    run_op("a3",   10'd3,   10'd254, 1'b0);
    run_op("a760", 10'd760, 10'd760, 1'b0);
    run_op("a763", 10'd763, 10'd381, 1'b0);
    run_op("a0",   10'd0,   10'd0,   1'b1);
    run_op("a761", 10'd761, 10'd0,   1'b1);

    // Backpressure: hold out_ready low for 5 cycles with a stray operand offered.
    @(negedge clk);
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.in_a      = 10'd3;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_a     = 10'd7;
      @(posedge clk); #1;
      check("bp_valid_held", {31'd0, ifc.out_valid}, 1);
      check("bp_out_r_held", {22'd0, ifc.out_r}, 254);
      check("bp_in_ready",   {31'd0, ifc.in_ready}, 0);
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", {31'd0, ifc.out_valid}, 0);
    check("bp_release_ready", {31'd0, ifc.in_ready}, 1);
    run_op("after_bp", 10'd2, 10'd381, 1'b0);

    // Reset in the middle of a computation.
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.in_a     = 10'd5;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    check("mid_busy", {31'd0, ifc.in_ready}, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_in_ready",  {31'd0, ifc.in_ready}, 1);
    check("mid_rst_out_valid", {31'd0, ifc.out_valid}, 0);
    check("mid_rst_out_r",     {22'd0, ifc.out_r}, 0);
    check("mid_rst_out_zero",  {31'd0, ifc.out_zero}, 0);
    @(negedge clk); rst = 1'b0;
    run_op("a5", 10'd5, 10'd609, 1'b0);

    // Sweep of all nonzero residues against the search reference.
    for (int a = 1; a < 761; a++)
      run_op($sformatf("sweep%0d", a), 10'(a), 10'(ref_inv(a)), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
